// File: rtl/device_cmd_transmitter.sv
// Serialises a command request and its 16-bit data words into a cs_n-framed byte stream.
// First strobe CS_SETUP+1 cycles after start; a word high byte waits in GAP until wr_data_valid.
module device_cmd_transmitter #(
  parameter int ADDRESS_WIDTH = 25,
  parameter int DATA_WIDTH    = 16,
  parameter int COUNT_WIDTH   = 16,
  parameter int CS_SETUP      = 4,
  parameter int BYTE_GAP      = 3,
  parameter int CS_HOLD       = 4,
  parameter int CS_IDLE       = 8
) (
  input  logic                     clk_device,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [7:0]               cmd_code,
  input  logic [ADDRESS_WIDTH-1:0] cmd_address,
  input  logic [COUNT_WIDTH-1:0]   cmd_word_count,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_data_valid,
  output logic                     wr_data_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     cs_n,
  output logic [7:0]               tx_byte,
  output logic                     tx_byte_valid
);

  localparam logic [7:0] CODE_WRITE = 8'd10;
  localparam logic [7:0] CODE_FLIP  = 8'd20;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SEND, S_GAP, S_HOLD, S_RECOVER
  } state_t;

  typedef enum logic [1:0] {PH_HDR, PH_HI, PH_LO} phase_t;

  state_t                   state, state_nxt;
  phase_t                   phase;
  logic [7:0]               tmr, tmr_nxt, tmr_lim;
  logic [7:0]               code_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [COUNT_WIDTH-1:0]   words_left;
  logic [2:0]               hdr_idx;
  logic [7:0]               lo_q;
  logic [7:0]               tx_byte_q;
  logic [7:0]               byte_cur;
  logic [31:0]              addr32;
  logic [2:0]               hdr_last;
  logic                     is_write;
  logic                     more_bytes;

  assign addr32   = 32'(addr_q);
  assign is_write = (code_q == CODE_WRITE);
  assign hdr_last = (code_q == CODE_FLIP) ? 3'd0 : 3'd4;

  always_comb begin
    byte_cur   = 8'h00;
    more_bytes = 1'b0;
    case (phase)
      PH_HDR: begin
        case (hdr_idx)
          3'd0:    byte_cur = code_q;
          3'd1:    byte_cur = addr32[31:24];
          3'd2:    byte_cur = addr32[23:16];
          3'd3:    byte_cur = addr32[15:8];
          3'd4:    byte_cur = addr32[7:0];
          default: byte_cur = 8'h00;
        endcase
        more_bytes = (hdr_idx != hdr_last) ||
                     (is_write && (words_left != '0));
      end
      PH_HI: begin
        byte_cur   = wr_data[15:8];
        more_bytes = 1'b1;
      end
      PH_LO: begin
        byte_cur   = lo_q;
        more_bytes = (words_left != COUNT_WIDTH'(1));
      end
      default: begin
        byte_cur   = 8'h00;
        more_bytes = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    tmr_lim   = 8'd0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        tmr_lim = 8'(CS_SETUP - 1);
        if (tmr == tmr_lim) state_nxt = S_SEND;
      end
      S_SEND: begin
        state_nxt = more_bytes ? S_GAP : S_HOLD;
      end
      S_GAP: begin
        // A pending high byte cannot leave GAP until the source has a word.
        tmr_lim = 8'(BYTE_GAP - 1);
        if ((tmr == tmr_lim) && ((phase != PH_HI) || wr_data_valid))
          state_nxt = S_SEND;
      end
      S_HOLD: begin
        tmr_lim = 8'(CS_HOLD - 1);
        if (tmr == tmr_lim) state_nxt = S_RECOVER;
      end
      S_RECOVER: begin
        tmr_lim = 8'(CS_IDLE - 1);
        if (tmr == tmr_lim) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt != state) tmr_nxt = 8'd0;
    else if (tmr == tmr_lim) tmr_nxt = tmr;
    else                     tmr_nxt = tmr + 8'd1;
  end

  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      phase      <= PH_HDR;
      tmr        <= 8'd0;
      code_q     <= 8'd0;
      addr_q     <= '0;
      words_left <= '0;
      hdr_idx    <= 3'd0;
      lo_q       <= 8'd0;
      tx_byte_q  <= 8'd0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      if (state == S_IDLE && start) begin
        code_q     <= cmd_code;
        addr_q     <= cmd_address;
        words_left <= cmd_word_count;
        hdr_idx    <= 3'd0;
        phase      <= PH_HDR;
      end
      if (state == S_SEND) begin
        tx_byte_q <= byte_cur;
        case (phase)
          PH_HDR: begin
            if (hdr_idx == hdr_last) begin
              if (is_write && (words_left != '0)) phase <= PH_HI;
            end else begin
              hdr_idx <= hdr_idx + 3'd1;
            end
          end
          PH_HI: begin
            lo_q  <= wr_data[7:0];
            phase <= PH_LO;
          end
          PH_LO: begin
            words_left <= words_left - COUNT_WIDTH'(1);
            phase      <= PH_HI;
          end
          default: phase <= PH_HDR;
        endcase
      end
    end
  end

  assign cs_n          = !((state == S_SETUP) || (state == S_SEND) ||
                           (state == S_GAP)   || (state == S_HOLD));
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_RECOVER) && (tmr == 8'd0);
  assign tx_byte_valid = (state == S_SEND);
  assign wr_data_ready = (state == S_SEND) && (phase == PH_HI);
  assign tx_byte       = tx_byte_valid ? byte_cur : tx_byte_q;

endmodule

// File: tb/tb_device_cmd_transmitter.sv
// Directed bench for device_cmd_transmitter: FLIP, WRITE, zero count, data stall, busy and reset.
module tb_device_cmd_transmitter;
  logic        clk_device = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cmd_code = 8'd0;
  logic [24:0] cmd_address = 25'd0;
  logic [15:0] cmd_word_count = 16'd0;
  logic [15:0] wr_data;
  logic        wr_data_valid;
  logic        wr_data_ready, busy, done, cs_n, tx_byte_valid;
  logic [7:0]  tx_byte;

  device_cmd_transmitter dut (
    .clk_device(clk_device), .reset_n(reset_n), .start(start),
    .cmd_code(cmd_code), .cmd_address(cmd_address), .cmd_word_count(cmd_word_count),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .busy(busy), .done(done), .cs_n(cs_n), .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid)
  );

  always #5 clk_device = ~clk_device;

  int cyc = 0;
  always @(posedge clk_device) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  logic [15:0] src_words [4];
  int          src_n = 0;
  int          src_idx = 0;
  bit          src_en = 1'b0;
  bit          adv_pending = 1'b0;

  always_comb begin
    wr_data       = (src_idx < 4) ? src_words[src_idx] : 16'h0000;
    wr_data_valid = src_en && (src_idx < src_n);
  end

  logic [7:0] sb_byte[$];
  int         sb_cyc[$];
  logic       sb_rdy[$];
  int         rdy_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = -1;
  logic [7:0] prev_byte = 8'd0;
  bit         prev_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Words advance one cycle after the ready pulse so the low byte latch sees a stable word.
  always @(negedge clk_device) begin
    if (adv_pending) src_idx++;
    adv_pending = wr_data_ready;
    if (tx_byte_valid) begin
      sb_byte.push_back(tx_byte);
      sb_cyc.push_back(cyc);
      sb_rdy.push_back(wr_data_ready);
      chk("strobe_needs_cs_low", {31'd0, cs_n}, 32'd0);
    end else if (reset_n && prev_rst) begin
      chk("tx_byte_hold", {24'd0, tx_byte}, {24'd0, prev_byte});
    end
    if (wr_data_ready) rdy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_byte = tx_byte;
    prev_rst  = reset_n;
  end

  task automatic clear_log();
    sb_byte.delete();
    sb_cyc.delete();
    sb_rdy.delete();
    rdy_cnt  = 0;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  // Called at a negedge; start is sampled at the following posedge (cycle t).
  task automatic send_start(input logic [7:0] code, input logic [24:0] addr,
                            input logic [15:0] cnt, output int t);
    cmd_code       = code;
    cmd_address    = addr;
    cmd_word_count = cnt;
    start          = 1'b1;
    t              = cyc;
    @(negedge clk_device);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int fall);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk_device);
      n++;
    end
    chk("idle_within_budget", {31'd0, busy}, 32'd0);
    fall = cyc;
  endtask

  logic [7:0] exp_w [9] = '{8'h0A, 8'h00, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h12, 8'h34};
  logic [7:0] exp_z [5] = '{8'h0A, 8'h01, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    int t, fall, n;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, fall, n;
    repeat (2) @(negedge clk_device);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_byte_valid}, 32'd0);
    chk("rst_ready", {31'd0, wr_data_ready}, 32'd0);
    chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk_device);

    // FLIP
    clear_log();
    send_start(8'd20, 25'd0, 16'd0, t);
    chk("flip_busy_t1", {31'd0, busy}, 32'd1);
    chk("flip_cs_t1", {31'd0, cs_n}, 32'd0);
    wait_idle(100, fall);
    chk("flip_busy_fall", fall, t + 18);
    chk("flip_nbytes", sb_byte.size(), 32'd1);
    chk("flip_byte", {24'd0, sb_byte[0]}, 32'h14);
    chk("flip_strobe_cyc", sb_cyc[0], t + 5);
    chk("flip_done_cnt", done_cnt, 32'd1);
    chk("flip_done_cyc", done_cyc, t + 10);
    chk("flip_no_ready", rdy_cnt, 32'd0);

    // WRITE two words, started the cycle after busy fell
    clear_log();
    src_words[0] = 16'hABCD; src_words[1] = 16'h1234;
    src_n = 2; src_idx = 0; src_en = 1'b1; adv_pending = 1'b0;
    send_start(8'd10, 25'h0001234, 16'd2, t);
    chk("wr_accepted", {31'd0, busy}, 32'd1);
    wait_idle(300, fall);
    chk("wr_nbytes", sb_byte.size(), 32'd9);
    chk("wr_first_cyc", sb_cyc[0], t + 5);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("wr_byte%0d", i), {24'd0, sb_byte[i]}, {24'd0, exp_w[i]});
      chk($sformatf("wr_rdy%0d", i), {31'd0, sb_rdy[i]}, (i == 5 || i == 7) ? 32'd1 : 32'd0);
      if (i > 0) chk($sformatf("wr_gap%0d", i), sb_cyc[i] - sb_cyc[i-1], 32'd4);
    end
    chk("wr_rdy_cnt", rdy_cnt, 32'd2);
    chk("wr_done_cyc", done_cyc, sb_cyc[8] + 5);

    // Full-width address, zero word count
    clear_log();
    src_en = 1'b0;
    send_start(8'd10, 25'h1FFFFFF, 16'd0, t);
    wait_idle(300, fall);
    chk("z_nbytes", sb_byte.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("z_byte%0d", i), {24'd0, sb_byte[i]}, {24'd0, exp_z[i]});
    chk("z_no_ready", rdy_cnt, 32'd0);
    chk("z_done_cnt", done_cnt, 32'd1);

    // Data stall: header ends at t+21, valid held low until t+41
    clear_log();
    src_words[0] = 16'hBEEF; src_n = 1; src_idx = 0; src_en = 1'b0; adv_pending = 1'b0;
    send_start(8'd10, 25'h0000055, 16'd1, t);
    repeat (40) @(negedge clk_device);
    chk("stall_nbytes", sb_byte.size(), 32'd5);
    chk("stall_cs_low", {31'd0, cs_n}, 32'd0);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    src_en = 1'b1;
    wait_idle(300, fall);
    chk("stall_nbytes_end", sb_byte.size(), 32'd7);
    chk("stall_hi", {24'd0, sb_byte[5]}, 32'hBE);
    chk("stall_lo", {24'd0, sb_byte[6]}, 32'hEF);
    chk("stall_gap", sb_cyc[5] - sb_cyc[4], 32'd21);
    chk("stall_lo_gap", sb_cyc[6] - sb_cyc[5], 32'd4);
    chk("stall_rdy_cnt", rdy_cnt, 32'd1);
    chk("stall_done_cnt", done_cnt, 32'd1);

    // start while busy is ignored
    clear_log();
    src_en = 1'b0;
    send_start(8'd20, 25'd0, 16'd0, t);
    repeat (2) @(negedge clk_device);
    cmd_code = 8'd10; start = 1'b1;
    @(negedge clk_device);
    start = 1'b0;
    repeat (8) @(negedge clk_device);
    start = 1'b1;
    @(negedge clk_device);
    start = 1'b0;
    wait_idle(100, fall);
    chk("busy_fall", fall, t + 18);
    chk("busy_nbytes", sb_byte.size(), 32'd1);
    chk("busy_byte", {24'd0, sb_byte[0]}, 32'h14);
    chk("busy_done_cnt", done_cnt, 32'd1);

    // Reset in the middle of the data phase
    clear_log();
    src_words[0] = 16'h1111; src_words[1] = 16'h2222; src_words[2] = 16'h3333;
    src_n = 3; src_idx = 0; src_en = 1'b1; adv_pending = 1'b0;
    send_start(8'd10, 25'h0000100, 16'd3, t);
    n = 0;
    while (rdy_cnt == 0 && n < 100) begin
      @(negedge clk_device);
      n++;
    end
    chk("rst_mid_reached_data", rdy_cnt, 32'd1);
    repeat (2) @(negedge clk_device);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_tx_valid", {31'd0, tx_byte_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, wr_data_ready}, 32'd0);
    chk("rst_mid_tx_byte", {24'd0, tx_byte}, 32'd0);
    repeat (3) @(negedge clk_device);
    chk("rst_mid_no_done", done_cnt, 32'd0);
    reset_n = 1'b1;
    src_en = 1'b0;
    @(negedge clk_device);
    clear_log();
    send_start(8'd20, 25'd0, 16'd0, t);
    wait_idle(100, fall);
    chk("post_rst_fall", fall, t + 18);
    chk("post_rst_nbytes", sb_byte.size(), 32'd1);
    chk("post_rst_byte", {24'd0, sb_byte[0]}, 32'h14);
    chk("post_rst_done", done_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
